// File: rtl/mc_cs_req_arb_pkg.sv
// mc_cs_req_arb_pkg: shared FSM encodings, timeout default and pointer helper for the CS request arbiter
package mc_cs_req_arb_pkg;
   typedef enum logic [1:0] {
      MC_ARB_IDLE  = 2'd0,
      MC_ARB_GRANT = 2'd1,
      MC_ARB_WAIT  = 2'd2,
      MC_ARB_HOLD  = 2'd3
   } arb_state_t;
   localparam int MC_TO_CYCLES_DEF = 1023;
   function automatic logic [2:0] cs_next(input logic [2:0] i, input int n);
      return (int'(i) == n - 1) ? 3'd0 : i + 3'd1;
   endfunction
endpackage

// File: rtl/mc_rr_pick.sv
// mc_rr_pick: combinational round-robin picker, first set request at or after ptr with wrap
//  req   in  N_CS  request vector
//  ptr   in  3     round-robin start index (always < N_CS)
//  valid out 1     any request set
//  idx   out 3     winning index
module mc_rr_pick #(
   parameter int N_CS = 8
) (
   input  logic [N_CS-1:0] req,
   input  logic [2:0]      ptr,
   output logic            valid,
   output logic [2:0]      idx
);
   logic [2:0] j;
   // scan from the farthest offset back toward ptr so the nearest set bit is written last
   always_comb begin
      valid = |req;
      idx = '0;
      j = '0;
      for (int i = N_CS - 1; i >= 0; i--) begin
         j = 3'((int'(ptr) + i) % N_CS);
         if (req[j]) idx = j;
      end
   end
endmodule

// File: rtl/mc_cs_req_arb.sv
// mc_cs_req_arb: arbitrates per-CS init/LMR requests onto the sequencer and routes its ack back
//  clk, rst                 clock, synchronous active-high reset
//  init_req, lmr_req        per-CS level requests, held until acked
//  init_ack, lmr_ack        one-cycle ack pulse to the granted CS
//  mc_init_req, mc_lmr_req  class request to the sequencer (never both)
//  mc_cs_sel                granted CS index while a request is active
//  mc_ack                   sequencer completion pulse
//  busy                     FSM not idle
//  to_err                   one-cycle pulse on grant timeout
module mc_cs_req_arb
   import mc_cs_req_arb_pkg::*;
#(
   parameter int N_CS      = 8,
   parameter int TO_CYCLES = MC_TO_CYCLES_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CS-1:0] init_req,
   input  logic [N_CS-1:0] lmr_req,
   output logic [N_CS-1:0] init_ack,
   output logic [N_CS-1:0] lmr_ack,
   output logic            mc_init_req,
   output logic            mc_lmr_req,
   output logic [2:0]      mc_cs_sel,
   input  logic            mc_ack,
   output logic            busy,
   output logic            to_err
);
   arb_state_t state, state_n;
   logic [2:0] rr_ptr, win, pick_idx;
   logic       cls, use_init, pick_valid, active, timeout, done;
   logic [9:0] cnt;
   logic [N_CS-1:0] pick_req;
   // init has absolute priority over LMR as a class
   assign use_init = |init_req;
   assign pick_req = use_init ? init_req : lmr_req;
   mc_rr_pick #(.N_CS(N_CS)) u_pick (
      .req   (pick_req),
      .ptr   (rr_ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );
   assign active      = (state == MC_ARB_GRANT) || (state == MC_ARB_WAIT);
   assign mc_init_req = active && cls;
   assign mc_lmr_req  = active && !cls;
   assign mc_cs_sel   = active ? win : 3'd0;
   assign busy        = state != MC_ARB_IDLE;
   // cnt is 0 on the first WAIT cycle, so this fires on the TO_CYCLES-th WAIT cycle
   assign timeout     = cnt == 10'(TO_CYCLES - 1);
   assign done        = (state == MC_ARB_WAIT) && (mc_ack || timeout);
   always_comb begin
      state_n = state == MC_ARB_IDLE  ? (pick_valid ? MC_ARB_GRANT : MC_ARB_IDLE) :
                state == MC_ARB_GRANT ? MC_ARB_WAIT :
                state == MC_ARB_WAIT  ? (done ? MC_ARB_HOLD : MC_ARB_WAIT) :
                                        MC_ARB_IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= MC_ARB_IDLE;
         rr_ptr   <= '0;
         win      <= '0;
         cls      <= 1'b0;
         cnt      <= '0;
         init_ack <= '0;
         lmr_ack  <= '0;
         to_err   <= 1'b0;
      end else begin
         state <= state_n;
         if (state == MC_ARB_IDLE && pick_valid) begin
            win <= pick_idx;
            cls <= use_init;
         end
         cnt      <= state == MC_ARB_GRANT ? 10'd0 : state == MC_ARB_WAIT ? cnt + 10'd1 : cnt;
         init_ack <= (state == MC_ARB_WAIT && mc_ack && cls)  ? N_CS'(1) << win : '0;
         lmr_ack  <= (state == MC_ARB_WAIT && mc_ack && !cls) ? N_CS'(1) << win : '0;
         // ack beats a coincident timeout
         to_err   <= state == MC_ARB_WAIT && timeout && !mc_ack;
         if (done) rr_ptr <= cs_next(win, N_CS);
      end
   end
endmodule

// File: tb/tb_mc_cs_req_arb.sv
// tb_mc_cs_req_arb: directed self-checking bench for mc_cs_req_arb
module tb_mc_cs_req_arb;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] init_req, lmr_req, init_ack, lmr_ack;
   logic       mc_init_req, mc_lmr_req, mc_ack, busy, to_err;
   logic [2:0] mc_cs_sel;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   mc_cs_req_arb dut (
      .clk         (clk),
      .rst         (rst),
      .init_req    (init_req),
      .lmr_req     (lmr_req),
      .init_ack    (init_ack),
      .lmr_ack     (lmr_ack),
      .mc_init_req (mc_init_req),
      .mc_lmr_req  (mc_lmr_req),
      .mc_cs_sel   (mc_cs_sel),
      .mc_ack      (mc_ack),
      .busy        (busy),
      .to_err      (to_err)
   );
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic chk_idle(input string tag);
      chk({tag, "_init_ack"}, init_ack, 8'h00);
      chk({tag, "_lmr_ack"}, lmr_ack, 8'h00);
      chk({tag, "_mc_init"}, 8'(mc_init_req), 8'h00);
      chk({tag, "_mc_lmr"}, 8'(mc_lmr_req), 8'h00);
      chk({tag, "_sel"}, 8'(mc_cs_sel), 8'h00);
      chk({tag, "_busy"}, 8'(busy), 8'h00);
      chk({tag, "_to_err"}, 8'(to_err), 8'h00);
   endtask
   initial begin
      rst = 1'b1; init_req = '0; lmr_req = '0; mc_ack = 1'b0;
      tick; tick;
      chk_idle("reset");
      rst = 1'b0;
      // 1: single init request on CS2
      init_req = 8'h04;
      tick;
      chk("t1_mc_init", 8'(mc_init_req), 8'h01);
      chk("t1_sel", 8'(mc_cs_sel), 8'h02);
      chk("t1_busy", 8'(busy), 8'h01);
      tick;
      chk("t1_wait_mc_init", 8'(mc_init_req), 8'h01);
      mc_ack = 1'b1;
      tick;
      mc_ack = 1'b0; init_req = '0;
      chk("t1_init_ack", init_ack, 8'h04);
      chk("t1_req_dropped", 8'(mc_init_req), 8'h00);
      chk("t1_hold_busy", 8'(busy), 8'h01);
      tick;
      chk("t1_ack_one_cycle", init_ack, 8'h00);
      chk("t1_busy_drop", 8'(busy), 8'h00);
      // 2: init beats LMR
      init_req = 8'h80; lmr_req = 8'h01;
      tick;
      chk("t2_mc_init", 8'(mc_init_req), 8'h01);
      chk("t2_mc_lmr_low", 8'(mc_lmr_req), 8'h00);
      chk("t2_sel", 8'(mc_cs_sel), 8'h07);
      tick;
      chk("t2_wait_mc_lmr_low", 8'(mc_lmr_req), 8'h00);
      mc_ack = 1'b1;
      tick;
      mc_ack = 1'b0; init_req = '0;
      chk("t2_init_ack", init_ack, 8'h80);
      chk("t2_no_lmr_ack", lmr_ack, 8'h00);
      tick;
      tick;
      chk("t2_lmr_grant", 8'(mc_lmr_req), 8'h01);
      chk("t2_lmr_init_low", 8'(mc_init_req), 8'h00);
      chk("t2_lmr_sel", 8'(mc_cs_sel), 8'h00);
      tick;
      mc_ack = 1'b1;
      tick;
      mc_ack = 1'b0; lmr_req = '0;
      chk("t2_lmr_ack", lmr_ack, 8'h01);
      tick;
      // 3: round-robin from a fresh pointer
      rst = 1'b1;
      tick;
      rst = 1'b0; lmr_req = 8'h0F;
      for (int k = 0; k < 4; k++) begin
         tick;
         chk($sformatf("t3_sel%0d", k), 8'(mc_cs_sel), 8'(k));
         chk($sformatf("t3_lmr%0d", k), 8'(mc_lmr_req), 8'h01);
         tick;
         mc_ack = 1'b1;
         tick;
         mc_ack = 1'b0;
         chk($sformatf("t3_ack%0d", k), lmr_ack, 8'(8'h01 << k));
         if (k == 3) lmr_req = 8'h01;
         tick;
      end
      tick;
      chk("t3_wrap_sel", 8'(mc_cs_sel), 8'h00);
      chk("t3_wrap_lmr", 8'(mc_lmr_req), 8'h01);
      tick;
      mc_ack = 1'b1;
      tick;
      mc_ack = 1'b0; lmr_req = '0;
      chk("t3_wrap_ack", lmr_ack, 8'h01);
      tick;
      // 4: timeout on CS4, request stays high
      init_req = 8'h10;
      tick;
      chk("t4_sel", 8'(mc_cs_sel), 8'h04);
      tick;
      repeat (1022) tick;
      chk("t4_pre_to_req", 8'(mc_init_req), 8'h01);
      chk("t4_pre_to_err", 8'(to_err), 8'h00);
      tick;
      chk("t4_to_err", 8'(to_err), 8'h01);
      chk("t4_req_dropped", 8'(mc_init_req), 8'h00);
      chk("t4_no_ack", init_ack, 8'h00);
      tick;
      chk("t4_to_err_pulse", 8'(to_err), 8'h00);
      chk("t4_idle", 8'(busy), 8'h00);
      tick;
      chk("t4_regrant", 8'(mc_init_req), 8'h01);
      chk("t4_regrant_sel", 8'(mc_cs_sel), 8'h04);
      // 5: ack on the exact timeout cycle
      tick;
      repeat (1022) tick;
      mc_ack = 1'b1;
      tick;
      mc_ack = 1'b0; init_req = '0;
      chk("t5_ack", init_ack, 8'h10);
      chk("t5_no_to_err", 8'(to_err), 8'h00);
      tick;
      // 6: reset mid-WAIT, then spurious ack
      init_req = 8'h02;
      tick; tick; tick;
      chk("t6_in_wait", 8'(mc_init_req), 8'h01);
      rst = 1'b1;
      tick;
      chk_idle("t6_reset");
      rst = 1'b0; init_req = '0; mc_ack = 1'b1;
      tick;
      mc_ack = 1'b0;
      chk_idle("t6_spurious");
      // pointer back at 0: CS0 must win over CS7
      lmr_req = 8'h81;
      tick;
      chk("t6_ptr_sel", 8'(mc_cs_sel), 8'h00);
      chk("t6_ptr_lmr", 8'(mc_lmr_req), 8'h01);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
